// File: rtl/hash_result_checker.sv
// hash_result_checker: consumes (hash, nonce) beats, compares each against a target
// latched at start, and reports the earliest winning nonce or exhaustion after
// MAX_TRIES beats, with a saturating attempt count.
// Optional feature macro: HASH_CHK_BEST_EN enables smallest-hash tracking on best_hash.
module hash_result_checker #(
  parameter int unsigned HASH_W    = 24,
  parameter int unsigned NONCE_W   = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_TRIES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [HASH_W-1:0]  target,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [HASH_W-1:0]  in_hash,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [CNT_W-1:0]   attempts,
  output logic [HASH_W-1:0]  best_hash
);

  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;

  localparam bit               LIMITED  = (MAX_TRIES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TRIES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t             state;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  stg_hash;
  logic [NONCE_W-1:0] stg_nonce;
  logic               stg_valid;
  logic               stg_last;
  logic               at_limit;
  logic               accept;
  logic               stg_win;

  // Ready is a pure decode of registered state, independent of in_valid.
  assign at_limit = LIMITED && (attempts == CNT_MAX);
  assign in_ready = (state == RUN) && !at_limit;
  assign accept   = in_valid && in_ready;
  assign stg_win  = stg_valid && (stg_hash < target_q);

  // Search FSM, compare stage, attempt counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      target_q    <= '0;
      stg_hash    <= '0;
      stg_nonce   <= '0;
      stg_valid   <= 1'b0;
      stg_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      attempts    <= '0;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            state       <= RUN;
            target_q    <= target;
            stg_valid   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            attempts    <= '0;
          end
        end
        RUN: begin
          // Every accepted beat counts, even one arriving alongside the winner.
          if (accept && (attempts != CNT_SAT)) begin
            attempts <= attempts + CNT_W'(1);
          end
          if (stg_win) begin
            state       <= FOUND;
            found       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            found_nonce <= stg_nonce;
            stg_valid   <= 1'b0;
          end else if (stg_valid && stg_last) begin
            state     <= EXHAUSTED;
            done      <= 1'b1;
            busy      <= 1'b0;
            stg_valid <= 1'b0;
          end else begin
            stg_valid <= accept;
            if (accept) begin
              stg_hash  <= in_hash;
              stg_nonce <= in_nonce;
              stg_last  <= LIMITED && (attempts == LAST_CNT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_CHK_BEST_EN
  // Running minimum of compared hashes; frozen outside RUN until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_hash <= '1;
    end else if ((state != RUN) && start) begin
      best_hash <= '1;
    end else if ((state == RUN) && stg_valid && (stg_hash < best_hash)) begin
      best_hash <= stg_hash;
    end
  end
`else
  assign best_hash = '1;
`endif

endmodule

// File: tb/tb_hash_result_checker.sv
// Bench for hash_result_checker: two instances (unlimited and MAX_TRIES=4) share
// stimulus; a transaction-level model predicts ready, status and counts each cycle.
module tb_hash_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] target;
  logic        in_valid;
  logic [23:0] in_hash;
  logic [31:0] in_nonce;

  logic        d_rdy   [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic        d_found [2];
  logic [31:0] d_fn    [2];
  logic [31:0] d_cnt   [2];
  logic [23:0] d_best  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hash_result_checker #(.HASH_W(24), .NONCE_W(32), .CNT_W(32), .MAX_TRIES(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(d_rdy[0]), .in_hash(in_hash), .in_nonce(in_nonce),
    .busy(d_busy[0]), .done(d_done[0]), .found(d_found[0]),
    .found_nonce(d_fn[0]), .attempts(d_cnt[0]), .best_hash(d_best[0])
  );

  hash_result_checker #(.HASH_W(24), .NONCE_W(32), .CNT_W(32), .MAX_TRIES(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(d_rdy[1]), .in_hash(in_hash), .in_nonce(in_nonce),
    .busy(d_busy[1]), .done(d_done[1]), .found(d_found[1]),
    .found_nonce(d_fn[1]), .attempts(d_cnt[1]), .best_hash(d_best[1])
  );

  // Reference model: one entry per instance; 'pend' is the beat waiting to be judged.
  bit          m_run   [2];
  bit          m_done  [2];
  bit          m_found [2];
  bit          m_pv    [2];
  bit          m_pl    [2];
  logic [23:0] m_tgt   [2];
  logic [23:0] m_ph    [2];
  logic [23:0] m_best  [2];
  logic [31:0] m_pn    [2];
  logic [31:0] m_fn    [2];
  logic [31:0] m_cnt   [2];

  function automatic int unsigned limit_of(int m);
    return (m == 0) ? 0 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 0; m_done[m] = 0; m_found[m] = 0; m_pv[m] = 0; m_pl[m] = 0;
      m_tgt[m] = '0; m_ph[m] = '0; m_pn[m] = '0; m_fn[m] = '0; m_cnt[m] = '0;
      m_best[m] = 24'hFFFFFF;
    end
  endtask

  task automatic check_outs(string pfx);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_d%0d_busy", pfx, m),  32'(d_busy[m]),  32'(m_run[m]));
      chk($sformatf("%s_d%0d_done", pfx, m),  32'(d_done[m]),  32'(m_done[m]));
      chk($sformatf("%s_d%0d_found", pfx, m), 32'(d_found[m]), 32'(m_found[m]));
      chk($sformatf("%s_d%0d_nonce", pfx, m), d_fn[m],         m_fn[m]);
      chk($sformatf("%s_d%0d_att", pfx, m),   d_cnt[m],        m_cnt[m]);
      chk($sformatf("%s_d%0d_best", pfx, m),  32'(d_best[m]),  32'(m_best[m]));
    end
  endtask

  // One clock: predict ready and the edge outcome from current inputs, then compare.
  task automatic tick(string pfx);
    bit rdy, acc;
    for (int m = 0; m < 2; m++) begin
      rdy = m_run[m] && !(limit_of(m) != 0 && m_cnt[m] == limit_of(m));
      chk($sformatf("%s_d%0d_ready", pfx, m), 32'(d_rdy[m]), 32'(rdy));
      if (!m_run[m]) begin
        if (start) begin
          m_run[m] = 1; m_tgt[m] = target; m_done[m] = 0; m_found[m] = 0;
          m_fn[m] = '0; m_cnt[m] = '0; m_pv[m] = 0; m_best[m] = 24'hFFFFFF;
        end
      end else begin
        acc = in_valid && rdy;
`ifdef HASH_CHK_BEST_EN
        if (m_pv[m] && m_ph[m] < m_best[m]) m_best[m] = m_ph[m];
`endif
        if (m_pv[m] && m_ph[m] < m_tgt[m]) begin
          m_run[m] = 0; m_found[m] = 1; m_done[m] = 1; m_fn[m] = m_pn[m]; m_pv[m] = 0;
        end else if (m_pv[m] && m_pl[m]) begin
          m_run[m] = 0; m_done[m] = 1; m_pv[m] = 0;
        end else begin
          m_pv[m] = acc;
          if (acc) begin
            m_ph[m] = in_hash; m_pn[m] = in_nonce;
            m_pl[m] = (limit_of(m) != 0) && (m_cnt[m] + 1 == limit_of(m));
          end
        end
        if (acc && m_cnt[m] != 32'hFFFFFFFF) m_cnt[m] = m_cnt[m] + 1;
      end
    end
    @(posedge clk);
    #1;
    check_outs(pfx);
  endtask

  task automatic beat(string pfx, bit v, logic [23:0] h, logic [31:0] n);
    in_valid = v; in_hash = h; in_nonce = n;
    tick(pfx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic kick(string pfx, logic [23:0] t);
    start = 1'b1; target = t; in_valid = 1'b0;
    tick(pfx);
    start = 1'b0;
  endtask

  logic [23:0] exp_best;

  initial begin
    rst = 1'b1; start = 1'b0; target = '0; in_valid = 1'b0; in_hash = '0; in_nonce = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst");
    rst = 1'b0;

    // Earliest winner after two losers; done follows the winning accept by one cycle.
    kick("t2", 24'h100000);
    beat("t2", 1, 24'h300000, 5);
    beat("t2", 1, 24'h200000, 6);
    beat("t2", 1, 24'h0FFFFF, 7);
    chk("t2_done_early", 32'(d_done[0]), 0);
    beat("t2", 0, 24'h0, 0);
    chk("t2_found", 32'(d_found[0]), 1);
    chk("t2_nonce", d_fn[0], 7);
    chk("t2_att", d_cnt[0], 3);
    chk("t2_done", 32'(d_done[0]), 1);

    // Exhaustion of the limited instance with an unwinnable target.
    do_reset();
    kick("t3", 24'h000000);
    for (int i = 0; i < 7; i++) beat("t3", 1, 24'(i * 3 + 1), 32'(20 + i));
    chk("t3_done", 32'(d_done[1]), 1);
    chk("t3_found", 32'(d_found[1]), 0);
    chk("t3_att", d_cnt[1], 4);
    chk("t3_ready", 32'(d_rdy[1]), 0);
    chk("t3_u0_att", d_cnt[0], 7);

    // Back-to-back winners: the first one sticks, the second is only counted.
    do_reset();
    kick("t4", 24'h000100);
    beat("t4", 1, 24'h000050, 10);
    beat("t4", 1, 24'h000020, 11);
    beat("t4", 0, 24'h0, 0);
    chk("t4_nonce", d_fn[0], 10);
    chk("t4_att", d_cnt[0], 2);
    chk("t4_nonce_lim", d_fn[1], 10);

    // Restart from FOUND, then a start pulse inside RUN is ignored.
    kick("t5", 24'h000010);
    chk("t5_busy", 32'(d_busy[0]), 1);
    chk("t5_att_clr", d_cnt[0], 0);
    chk("t5_found_clr", 32'(d_found[0]), 0);
    beat("t5", 1, 24'h800000, 30);
    start = 1'b1;
    beat("t5", 1, 24'h800001, 31);
    start = 1'b0;
    beat("t5", 0, 24'h0, 0);
    chk("t5_att_run", d_cnt[0], 2);
    chk("t5_busy_run", 32'(d_busy[0]), 1);

    // Smallest-hash tracking against an unwinnable target.
    do_reset();
    kick("t6", 24'h000000);
    beat("t6", 1, 24'h500000, 40);
    beat("t6", 1, 24'h200000, 41);
    beat("t6", 1, 24'h300000, 42);
    beat("t6", 0, 24'h0, 0);
`ifdef HASH_CHK_BEST_EN
    exp_best = 24'h200000;
`else
    exp_best = 24'hFFFFFF;
`endif
    chk("t6_best", 32'(d_best[0]), 32'(exp_best));

    // Asynchronous reset mid-cycle while a beat is offered.
    in_valid = 1'b1; in_hash = 24'h000001; in_nonce = 99;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t1_ready0", 32'(d_rdy[0]), 0);
    chk("t1_ready1", 32'(d_rdy[1]), 0);
    check_outs("t1");
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outs("t1_post");

    // Randomized searches, sometimes restarting from a finished state without reset.
    for (int it = 0; it < 40; it++) begin
      if (it % 3 == 0) do_reset();
      kick("rnd", ($urandom_range(0, 9) == 0) ? 24'h0 : 24'($urandom));
      for (int c = 0; c < 14; c++) begin
        start = ($urandom_range(0, 9) == 0);
        beat("rnd", ($urandom_range(0, 9) < 7), 24'($urandom), $urandom);
      end
      start = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
